snes_pad_reader: RTL

SNES_PAD_READER -- requirements
Module: snes_pad_reader

---
 rtl/snes_pad_reader_pkg.sv | 35 +++
 rtl/snes_pad_reader_sync.sv | 21 ++
 rtl/snes_pad_reader.sv | 122 ++++++++++++
 3 files changed

// File: rtl/snes_pad_reader_pkg.sv
// Shared types and constants for the SNES/NES controller reader.
package pad_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    BIT_HIGH,
    BIT_LOW,
    DONE
  } pad_state_t;

  localparam int unsigned SNES_BITS = 16;
  localparam int unsigned NES_BITS  = 8;

  // Button positions in the serial frame (SNES name / NES name where they differ)
  localparam int unsigned BTN_B_A    = 0;
  localparam int unsigned BTN_Y_B    = 1;
  localparam int unsigned BTN_SELECT = 2;
  localparam int unsigned BTN_START  = 3;
  localparam int unsigned BTN_UP     = 4;
  localparam int unsigned BTN_DOWN   = 5;
  localparam int unsigned BTN_LEFT   = 6;
  localparam int unsigned BTN_RIGHT  = 7;
  localparam int unsigned BTN_A      = 8;
  localparam int unsigned BTN_X      = 9;
  localparam int unsigned BTN_L      = 10;
  localparam int unsigned BTN_R      = 11;

  // A real SNES pad reports bits 12..15 as released; a floating NES line reads all pressed.
  function automatic logic frame_readable(input logic [15:0] pressed, input logic snes);
    if (snes) return (pressed[15:12] == 4'b0000);
    return (pressed[7:0] != 8'hFF);
  endfunction

endpackage

// File: rtl/snes_pad_reader_sync.sv
// Two-flop synchroniser for the asynchronous pad data line.
module pad_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/snes_pad_reader.sv
// Polls an SNES (16-bit) or NES (8-bit) controller and publishes the
// decoded, active-high button frame once per poll.
module snes_pad_reader #(
  parameter int unsigned LATCH_CYCLES    = 600,
  parameter int unsigned HALF_BIT_CYCLES = 300,
  parameter int unsigned POLL_CYCLES     = 833333
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Is_Snes,
  input  logic        Pad_Data,
  output logic        Pad_Latch,
  output logic        Pad_Clock,
  output logic [15:0] Buttons,
  output logic        NU,
  output logic        ND,
  output logic        NL,
  output logic        NR,
  output logic        NReadable
);

  import pad_pkg::*;

  localparam int unsigned POLL_W    = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam int unsigned PHASE_MAX = (LATCH_CYCLES > HALF_BIT_CYCLES) ? LATCH_CYCLES : HALF_BIT_CYCLES;
  localparam int unsigned PHASE_W   = (PHASE_MAX > 1) ? $clog2(PHASE_MAX) : 1;

  pad_state_t         state;
  pad_state_t         state_next;
  logic [POLL_W-1:0]  poll_cnt;
  logic [PHASE_W-1:0] phase_cnt;
  logic [3:0]         bit_idx;
  logic               frame_snes;
  logic [15:0]        shift;
  logic               data_s;
  logic               poll_done;
  logic               phase_done;
  logic               last_bit;

  pad_sync u_sync (
    .clk (Clock),
    .rst (Reset),
    .d   (Pad_Data),
    .q   (data_s)
  );

  always_comb begin
    poll_done  = (poll_cnt == POLL_W'(POLL_CYCLES - 1));
    phase_done = (state == LATCH) ? (phase_cnt == PHASE_W'(LATCH_CYCLES - 1))
                                  : (phase_cnt == PHASE_W'(HALF_BIT_CYCLES - 1));
    last_bit   = (bit_idx == (frame_snes ? 4'(SNES_BITS - 1) : 4'(NES_BITS - 1)));
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:     if (poll_done)  state_next = LATCH;
      LATCH:    if (phase_done) state_next = BIT_HIGH;
      BIT_HIGH: if (phase_done) state_next = last_bit ? DONE : BIT_LOW;
      BIT_LOW:  if (phase_done) state_next = BIT_HIGH;
      DONE:                     state_next = IDLE;
      default:                  state_next = IDLE;
    endcase
  end

  always_comb begin
    Pad_Latch = (state == LATCH);
    Pad_Clock = (state != BIT_LOW);
  end

  // Phase counter restarts on every state change so each phase lasts exactly its limit.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      poll_cnt  <= '0;
      phase_cnt <= '0;
    end else begin
      poll_cnt  <= (state == IDLE && !poll_done) ? poll_cnt + POLL_W'(1) : '0;
      phase_cnt <= (state_next != state || state == IDLE || state == DONE)
                   ? '0 : phase_cnt + PHASE_W'(1);
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      frame_snes <= 1'b0;
      bit_idx    <= '0;
      shift      <= '0;
    end else begin
      if (state == IDLE && poll_done) begin
        frame_snes <= Is_Snes;
        bit_idx    <= '0;
        shift      <= '0;
      end
      if (state == BIT_HIGH && phase_done) shift[bit_idx] <= ~data_s;
      if (state == BIT_LOW && phase_done)  bit_idx <= bit_idx + 4'd1;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      Buttons   <= '0;
      NU        <= 1'b0;
      ND        <= 1'b0;
      NL        <= 1'b0;
      NR        <= 1'b0;
      NReadable <= 1'b0;
    end else if (state == DONE) begin
      Buttons   <= shift;
      NU        <= shift[BTN_UP];
      ND        <= shift[BTN_DOWN];
      NL        <= shift[BTN_LEFT];
      NR        <= shift[BTN_RIGHT];
      NReadable <= frame_readable(shift, frame_snes);
    end
  end

endmodule
